// File: rtl/level_sequencer_if.sv
// Link between the game-flow sequencer and the selected level instance.
// The sequencer is the master: it picks the level and drives its reset; the level reports win/lose.
interface level_sequencer_if;
    logic       level_win;
    logic       level_lose;
    logic [1:0] level_select;
    logic       level_reset_n;

    modport master (
        input  level_win,
        input  level_lose,
        output level_select,
        output level_reset_n
    );

    modport slave (
        output level_win,
        output level_lose,
        input  level_select,
        input  level_reset_n
    );
endinterface

// File: rtl/level_sequencer.sv
// Game-flow FSM: title, level load, play, result screens, lives and game over/won.
// State encoding doubles as the VGA screen-mode code.
module level_sequencer #(
    parameter int unsigned NUM_LEVELS         = 3,
    parameter int unsigned LIVES              = 3,
    parameter int unsigned LEVEL_RESET_CYCLES = 4,
    parameter int unsigned RESULT_HOLD_CYCLES = 50_000_000
) (
    input  logic                vga_clock,
    input  logic                reset,
    input  logic                start_n,
    level_sequencer_if.master   lvl,
    output logic [2:0]          screen_mode,
    output logic [1:0]          lives_left,
    output logic                playing
);

    typedef enum logic [2:0] {
        StPlay     = 3'd0,
        StTitle    = 3'd1,
        StClear    = 3'd2,
        StDead     = 3'd3,
        StGameOver = 3'd4,
        StGameWon  = 3'd5,
        StLoad     = 3'd6
    } state_e;

    localparam logic [1:0]  LastLevel = 2'(NUM_LEVELS - 1);
    localparam logic [1:0]  FullLives = 2'(LIVES);
    localparam logic [31:0] LoadLast  = 32'(LEVEL_RESET_CYCLES - 1);
    localparam logic [31:0] HoldLoad  = 32'(RESULT_HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  select_q, select_d;
    logic [1:0]  lives_q, lives_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] load_cnt_q, load_cnt_d;
    logic [2:0]  mode_q;
    logic        playing_q;
    logic        level_reset_n_q;
    // [0],[1] synchronize the pin; [2] is the previous synchronized value for edge detection.
    logic [2:0]  start_sync_q;
    logic        start_evt;

    assign start_evt = start_sync_q[2] & ~start_sync_q[1];

    always_comb begin
        state_d    = state_q;
        select_d   = select_q;
        lives_d    = lives_q;
        timer_d    = timer_q;
        load_cnt_d = load_cnt_q;
        case (state_q)
            StTitle: begin
                if (start_evt) begin
                    state_d    = StLoad;
                    select_d   = 2'd0;
                    lives_d    = FullLives;
                    load_cnt_d = 32'd0;
                end
            end
            StLoad: begin
                if (load_cnt_q >= LoadLast) begin
                    state_d = StPlay;
                end else begin
                    load_cnt_d = load_cnt_q + 32'd1;
                end
            end
            StPlay: begin
                // Win takes priority over a simultaneous lose.
                if (lvl.level_win) begin
                    state_d = StClear;
                    timer_d = HoldLoad;
                end else if (lvl.level_lose) begin
                    state_d = StDead;
                    timer_d = HoldLoad;
                end
            end
            StClear: begin
                if (timer_q == 32'd0) begin
                    if (select_q >= LastLevel) begin
                        state_d = StGameWon;
                    end else begin
                        state_d    = StLoad;
                        select_d   = select_q + 2'd1;
                        load_cnt_d = 32'd0;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            StDead: begin
                if (timer_q == 32'd0) begin
                    if (lives_q <= 2'd1) begin
                        state_d = StGameOver;
                        lives_d = 2'd0;
                    end else begin
                        state_d    = StLoad;
                        lives_d    = lives_q - 2'd1;
                        load_cnt_d = 32'd0;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            StGameOver, StGameWon: begin
                if (start_evt) begin
                    state_d = StTitle;
                end
            end
            default: state_d = StTitle;
        endcase
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state_q         <= StTitle;
            select_q        <= 2'd0;
            lives_q         <= FullLives;
            timer_q         <= 32'd0;
            load_cnt_q      <= 32'd0;
            mode_q          <= 3'd1;
            playing_q       <= 1'b0;
            level_reset_n_q <= 1'b0;
            start_sync_q    <= 3'b111;
        end else begin
            state_q         <= state_d;
            select_q        <= select_d;
            lives_q         <= lives_d;
            timer_q         <= timer_d;
            load_cnt_q      <= load_cnt_d;
            mode_q          <= state_d;
            playing_q       <= (state_d == StPlay);
            // Level stays out of reset on result screens so its last frame remains visible.
            level_reset_n_q <= (state_d == StPlay) || (state_d == StClear) || (state_d == StDead);
            start_sync_q    <= {start_sync_q[1:0], start_n};
        end
    end

    assign lvl.level_select  = select_q;
    assign lvl.level_reset_n = level_reset_n_q;
    assign screen_mode       = mode_q;
    assign lives_left        = lives_q;
    assign playing           = playing_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench: each expected screen transition is queued before stimulus and checked
// (fields and dwell time) when the DUT's screen_mode changes.
module tb_level_sequencer;

    typedef struct {
        logic [2:0] mode;
        logic [1:0] sel;
        logic [1:0] lives;
        logic       rstn;
        int         dwell;  // expected cycles in this screen, 0 = not checked
    } exp_t;

    logic       vga_clock = 1'b0;
    logic       reset     = 1'b0;
    logic       start_n   = 1'b1;
    logic [2:0] screen_mode;
    logic [1:0] lives_left;
    logic       playing;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    level_sequencer_if lvl_if ();

    level_sequencer #(
        .NUM_LEVELS        (3),
        .LIVES             (2),
        .LEVEL_RESET_CYCLES(4),
        .RESULT_HOLD_CYCLES(8)
    ) dut (
        .vga_clock  (vga_clock),
        .reset      (reset),
        .start_n    (start_n),
        .lvl        (lvl_if.master),
        .screen_mode(screen_mode),
        .lives_left (lives_left),
        .playing    (playing)
    );

    always #20 vga_clock = ~vga_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [2:0] m, input logic [1:0] s, input logic [1:0] l,
                        input logic r, input int d);
        exp_t e;
        e.mode  = m;
        e.sel   = s;
        e.lives = l;
        e.rstn  = r;
        e.dwell = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_mode(input logic [2:0] m);
        int n = 0;
        while (screen_mode !== m && n < 300) begin
            @(negedge vga_clock);
            n++;
        end
        if (n >= 300) chk("timeout_wait_mode", 32'(screen_mode), 32'(m));
    endtask

    task automatic start_pulse();
        start_n = 1'b0;
        @(negedge vga_clock);
        start_n = 1'b1;
    endtask

    // Monitor: on every screen change, check the finished screen's dwell and the new screen's fields.
    initial begin : monitor
        logic [2:0] prev_mode;
        int dwell;
        int prev_dwell_exp;
        exp_t e;
        prev_mode      = 3'd1;
        dwell          = 0;
        prev_dwell_exp = 0;
        @(posedge reset);
        forever begin
            @(negedge vga_clock);
            if (screen_mode !== prev_mode) begin
                if (prev_dwell_exp != 0) chk("dwell", 32'(dwell), 32'(prev_dwell_exp));
                if (exp_q.size() == 0) begin
                    chk("unexpected_screen", 32'(screen_mode), 32'(prev_mode));
                    prev_dwell_exp = 0;
                end else begin
                    e = exp_q.pop_front();
                    chk("mode", 32'(screen_mode), 32'(e.mode));
                    chk("level_select", 32'(lvl_if.level_select), 32'(e.sel));
                    chk("lives_left", 32'(lives_left), 32'(e.lives));
                    chk("level_reset_n", 32'(lvl_if.level_reset_n), 32'(e.rstn));
                    chk("playing", 32'(playing), 32'(e.mode == 3'd0));
                    prev_dwell_exp = e.dwell;
                end
                dwell = 1;
            end else begin
                dwell++;
            end
            prev_mode = screen_mode;
        end
    end

    initial begin : stim
        int lat;
        lvl_if.level_win  = 1'b0;
        lvl_if.level_lose = 1'b0;
        repeat (3) @(negedge vga_clock);
        chk("rst_mode", 32'(screen_mode), 32'd1);
        chk("rst_select", 32'(lvl_if.level_select), 32'd0);
        chk("rst_lives", 32'(lives_left), 32'd2);
        chk("rst_level_reset_n", 32'(lvl_if.level_reset_n), 32'd0);
        chk("rst_playing", 32'(playing), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge vga_clock);

        // Start: 3-cycle latency, LOAD for 4 cycles, then PLAY on level 0.
        push(3'd6, 2'd0, 2'd2, 1'b0, 4);
        push(3'd0, 2'd0, 2'd2, 1'b1, 0);
        start_n = 1'b0;
        lat = 0;
        while (screen_mode !== 3'd6 && lat < 20) begin
            @(negedge vga_clock);
            lat++;
            start_n = 1'b1;
        end
        chk("start_latency", 32'(lat), 32'd3);
        wait_mode(3'd0);

        // Win on level 0; win held in LOAD is ignored.
        push(3'd2, 2'd0, 2'd2, 1'b1, 8);
        push(3'd6, 2'd1, 2'd2, 1'b0, 4);
        push(3'd0, 2'd1, 2'd2, 1'b1, 0);
        lvl_if.level_win = 1'b1;
        wait_mode(3'd6);
        repeat (2) @(negedge vga_clock);
        lvl_if.level_win = 1'b0;
        wait_mode(3'd0);

        // Win and lose together: CLEAR wins, lives unchanged.
        push(3'd2, 2'd1, 2'd2, 1'b1, 8);
        push(3'd6, 2'd2, 2'd2, 1'b0, 4);
        push(3'd0, 2'd2, 2'd2, 1'b1, 0);
        lvl_if.level_win  = 1'b1;
        lvl_if.level_lose = 1'b1;
        wait_mode(3'd2);
        lvl_if.level_win  = 1'b0;
        lvl_if.level_lose = 1'b0;
        wait_mode(3'd0);

        // Two deaths with two lives: reload same level, then GAME_OVER.
        push(3'd3, 2'd2, 2'd2, 1'b1, 8);
        push(3'd6, 2'd2, 2'd1, 1'b0, 4);
        push(3'd0, 2'd2, 2'd1, 1'b1, 0);
        push(3'd3, 2'd2, 2'd1, 1'b1, 8);
        push(3'd4, 2'd2, 2'd0, 1'b0, 0);
        lvl_if.level_lose = 1'b1;
        wait_mode(3'd3);
        lvl_if.level_lose = 1'b0;
        wait_mode(3'd0);
        lvl_if.level_lose = 1'b1;
        wait_mode(3'd3);
        lvl_if.level_lose = 1'b0;
        wait_mode(3'd4);

        // Back to TITLE (select/lives kept), then a fresh game.
        push(3'd1, 2'd2, 2'd0, 1'b0, 0);
        push(3'd6, 2'd0, 2'd2, 1'b0, 4);
        push(3'd0, 2'd0, 2'd2, 1'b1, 0);
        start_pulse();
        wait_mode(3'd1);
        repeat (2) @(negedge vga_clock);
        start_pulse();
        wait_mode(3'd0);

        // Clear all three levels -> GAME_WON.
        for (int lv = 0; lv < 3; lv++) begin
            push(3'd2, 2'(lv), 2'd2, 1'b1, 8);
            if (lv < 2) begin
                push(3'd6, 2'(lv + 1), 2'd2, 1'b0, 4);
                push(3'd0, 2'(lv + 1), 2'd2, 1'b1, 0);
            end else begin
                push(3'd5, 2'd2, 2'd2, 1'b0, 0);
            end
            lvl_if.level_win = 1'b1;
            wait_mode(3'd2);
            lvl_if.level_win = 1'b0;
            wait_mode((lv < 2) ? 3'd0 : 3'd5);
        end

        // Holding start low gives one event only: TITLE and nothing further.
        push(3'd1, 2'd2, 2'd2, 1'b0, 0);
        start_n = 1'b0;
        repeat (100) @(negedge vga_clock);
        start_n = 1'b1;
        chk("hold_start_mode", 32'(screen_mode), 32'd1);
        repeat (4) @(negedge vga_clock);

        // New game, die, then assert reset with the DEAD timer at 3.
        push(3'd6, 2'd0, 2'd2, 1'b0, 4);
        push(3'd0, 2'd0, 2'd2, 1'b1, 0);
        push(3'd3, 2'd0, 2'd2, 1'b1, 0);
        start_pulse();
        wait_mode(3'd0);
        lvl_if.level_lose = 1'b1;
        wait_mode(3'd3);
        lvl_if.level_lose = 1'b0;
        repeat (4) @(negedge vga_clock);
        #1;
        push(3'd1, 2'd0, 2'd2, 1'b0, 0);
        reset = 1'b0;
        #1;
        chk("async_rst_mode", 32'(screen_mode), 32'd1);
        chk("async_rst_level_reset_n", 32'(lvl_if.level_reset_n), 32'd0);
        chk("async_rst_lives", 32'(lives_left), 32'd2);
        chk("async_rst_playing", 32'(playing), 32'd0);
        @(negedge vga_clock);
        reset = 1'b1;
        repeat (5) @(negedge vga_clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
